// File: rtl/edit_if.sv
// Handshake bundle between the mode FSM and the edit controller:
// the mode FSM state and raw button in, decoded edit target, field and strobes out.
interface edit_if;
  logic [3:0] state;
  logic       inc_btn;
  logic [1:0] target;
  logic [2:0] field_sel;
  logic       inc_pulse;
  logic       blink_on;

  modport master (output state, inc_btn,
                  input  target, field_sel, inc_pulse, blink_on);
  modport slave  (input  state, inc_btn,
                  output target, field_sel, inc_pulse, blink_on);
endinterface

// File: rtl/edit_controller.sv
// Edit-mode sequencer: decodes the mode state into counter/field selects, turns the
// increment button into debounced auto-repeat pulses and blinks the field being edited.
module edit_controller #(
  parameter int DEBOUNCE_CYC   = 2_000_000,
  parameter int HOLD_CYC       = 50_000_000,
  parameter int REPEAT_CYC     = 10_000_000,
  parameter int BLINK_HALF_CYC = 25_000_000
) (
  input  logic  clk,
  input  logic  rst_n,
  edit_if.slave eif
);

  typedef enum logic [2:0] {IDLE, DEBOUNCE, HOLD, REPEAT, LOCKOUT} btn_st_e;

  localparam logic [25:0] DEB_LAST = 26'(DEBOUNCE_CYC - 1);
  localparam logic [25:0] HLD_LAST = 26'(HOLD_CYC - 1);
  localparam logic [25:0] REP_LAST = 26'(REPEAT_CYC - 1);
  localparam logic [25:0] BLK_LAST = 26'(BLINK_HALF_CYC - 1);

  logic [3:0]  state_q;
  logic [1:0]  tgt_d;
  logic [2:0]  fld_d;
  logic        edit_d, chg, busy;
  logic [1:0]  sync_q;
  logic        btn_s;
  btn_st_e     fsm_q, fsm_d;
  logic [25:0] cnt_q, cnt_d;
  logic        pulse_d;
  logic [25:0] bcnt_q;

  assign btn_s  = sync_q[1];
  assign edit_d = (tgt_d != 2'd0);
  assign chg    = (eif.state != state_q);
  assign busy   = (fsm_q == DEBOUNCE) || (fsm_q == HOLD) || (fsm_q == REPEAT);

  always_comb begin
    tgt_d = 2'd0;
    fld_d = 3'd0;
    case (eif.state)
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
        tgt_d = 2'd1;
        fld_d = 3'(eif.state - 4'd1);
      end
      4'd9, 4'd10, 4'd11: begin
        tgt_d = 2'd2;
        fld_d = 3'(eif.state - 4'd8);
      end
      4'd13, 4'd14, 4'd15: begin
        tgt_d = 2'd3;
        fld_d = 3'(eif.state - 4'd12);
      end
      default: ;
    endcase
  end

  // Decisions use the live state so the registered pulse lines up with the registered target.
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (!edit_d) begin
      fsm_d = btn_s ? LOCKOUT : IDLE;
      cnt_d = '0;
    end else if (chg && (busy || btn_s)) begin
      fsm_d = LOCKOUT;
      cnt_d = '0;
    end else begin
      case (fsm_q)
        IDLE: if (btn_s) begin
          fsm_d = DEBOUNCE;
          cnt_d = '0;
        end
        DEBOUNCE: begin
          if (!btn_s) fsm_d = IDLE;
          else if (cnt_q == DEB_LAST) begin
            pulse_d = 1'b1;
            fsm_d   = HOLD;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 26'd1;
        end
        HOLD: begin
          if (!btn_s) fsm_d = IDLE;
          else if (cnt_q == HLD_LAST) begin
            pulse_d = 1'b1;
            fsm_d   = REPEAT;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 26'd1;
        end
        REPEAT: begin
          if (!btn_s) fsm_d = IDLE;
          else if (cnt_q == REP_LAST) begin
            pulse_d = 1'b1;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 26'd1;
        end
        LOCKOUT: if (!btn_s) fsm_d = IDLE;
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= '0;
      eif.target    <= '0;
      eif.field_sel <= '0;
      sync_q        <= '0;
      fsm_q         <= IDLE;
      cnt_q         <= '0;
      eif.inc_pulse <= 1'b0;
    end else begin
      state_q       <= eif.state;
      eif.target    <= tgt_d;
      eif.field_sel <= fld_d;
      sync_q        <= {sync_q[0], eif.inc_btn};
      fsm_q         <= fsm_d;
      cnt_q         <= cnt_d;
      eif.inc_pulse <= pulse_d;
    end
  end

  // Keep the digits solid while the user is holding the button to scroll values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q       <= '0;
      eif.blink_on <= 1'b1;
    end else if (!edit_d || chg || fsm_d == HOLD || fsm_d == REPEAT) begin
      bcnt_q       <= '0;
      eif.blink_on <= 1'b1;
    end else if (bcnt_q == BLK_LAST) begin
      bcnt_q       <= '0;
      eif.blink_on <= ~eif.blink_on;
    end else begin
      bcnt_q <= bcnt_q + 26'd1;
    end
  end

endmodule

// File: tb/tb_edit_controller.sv
// Bench for edit_controller: expected pulse edges go into a scoreboard queue when the
// button is driven and are popped as the DUT strobes inc_pulse.
module tb_edit_controller;
  localparam int D = 4, H = 8, R = 3, B = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_q[$];
  int   mon_e;
  int   base;

  edit_if eif ();

  edit_controller #(.DEBOUNCE_CYC(D), .HOLD_CYC(H), .REPEAT_CYC(R), .BLINK_HALF_CYC(B))
    dut (.clk(clk), .rst_n(rst_n), .eif(eif));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard consumer: every strobe must match the oldest expected edge.
  always @(negedge clk) begin
    if (eif.inc_pulse === 1'b1) begin
      chk("pulse_tgt_nz", int'(eif.target != 2'd0), 1);
      if (exp_q.size() == 0) chk("spurious_pulse", cyc, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("pulse_edge", cyc, mon_e);
      end
    end
  end

  task automatic set_state(input logic [3:0] s, input int t, input int f);
    eif.state = s;
    tick(2);
    chk("target", int'(eif.target), t);
    chk("field_sel", int'(eif.field_sel), f);
  endtask

  initial begin
    eif.state   = 4'd0;
    eif.inc_btn = 1'b0;
    tick(2);
    chk("rst_target", int'(eif.target), 0);
    chk("rst_field", int'(eif.field_sel), 0);
    chk("rst_pulse", int'(eif.inc_pulse), 0);
    chk("rst_blink", int'(eif.blink_on), 1);
    rst_n = 1'b1;
    tick(2);

    // single press shorter than debounce+hold: exactly one pulse at edge D+3
    set_state(4'd4, 1, 3);
    base = cyc;
    exp_q.push_back(base + D + 3);
    eif.inc_btn = 1'b1;
    tick(6);
    eif.inc_btn = 1'b0;
    tick(20);
    chk("sb_empty_single", exp_q.size(), 0);

    // long hold: first pulse, hold pulse, then repeats; blink solid while held
    set_state(4'd10, 2, 2);
    base = cyc;
    exp_q.push_back(base + D + 3);
    for (int e = D + 3 + H; e <= 42; e += R) exp_q.push_back(base + e);
    eif.inc_btn = 1'b1;
    for (int i = 1; i <= 42; i++) begin
      @(negedge clk);
      if (i == 40) eif.inc_btn = 1'b0;
      if (i >= D + 3) chk("blink_hold", int'(eif.blink_on), 1);
    end
    tick(10);
    chk("sb_empty_hold", exp_q.size(), 0);

    // held in a display state, then carried into an edit state: locked out
    set_state(4'd0, 0, 0);
    eif.inc_btn = 1'b1;
    tick(30);
    chk("disp_target", int'(eif.target), 0);
    eif.state = 4'd3;
    tick(2);
    chk("lock_target", int'(eif.target), 1);
    chk("lock_field", int'(eif.field_sel), 2);
    tick(10);
    eif.inc_btn = 1'b0;
    tick(5);
    base = cyc;
    exp_q.push_back(base + D + 3);
    eif.inc_btn = 1'b1;
    tick(6);
    eif.inc_btn = 1'b0;
    tick(15);
    chk("sb_empty_lockout", exp_q.size(), 0);

    // short glitches never survive the debounce
    set_state(4'd5, 1, 4);
    for (int i = 0; i < 10; i++) begin
      eif.inc_btn = 1'b1;
      tick(1);
      eif.inc_btn = 1'b0;
      tick(2);
    end
    tick(10);
    chk("sb_empty_glitch", exp_q.size(), 0);

    // blink cadence, and restart on a state change in the blanked phase
    eif.state = 4'd13;
    base = cyc;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      chk("blink_13", int'(eif.blink_on), int'(((k - 1) / B) % 2 == 0));
    end
    eif.state = 4'd14;
    base = cyc;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("blink_14", int'(eif.blink_on), int'(((k - 1) / B) % 2 == 0));
    end
    chk("field_14", int'(eif.field_sel), 2);

    // async reset during REPEAT, then a full debounce after release
    set_state(4'd15, 3, 3);
    base = cyc;
    exp_q.push_back(base + D + 3);
    exp_q.push_back(base + D + 3 + H);
    exp_q.push_back(base + D + 3 + H + R);
    eif.inc_btn = 1'b1;
    tick(19);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_target", int'(eif.target), 0);
    chk("arst_field", int'(eif.field_sel), 0);
    chk("arst_pulse", int'(eif.inc_pulse), 0);
    chk("arst_blink", int'(eif.blink_on), 1);
    chk("sb_empty_prerst", exp_q.size(), 0);
    tick(2);
    rst_n = 1'b1;
    base = cyc;
    exp_q.push_back(base + D + 3);
    tick(10);
    eif.inc_btn = 1'b0;
    tick(10);
    chk("sb_empty_postrst", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
